axis_packet_arbiter: RTL

AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

---
 rtl/axis_packet_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-level arbiter that merges CHANNELS AXI-Stream
// requesters onto one output stream. A grant is held for a whole packet, so
// packets are never interleaved, and every packet is followed by one IDLE cycle.
// The output is a single register stage that also carries the source index on tid.
//
// Optional build macro AXIS_ARB_FIXED_PRIO_EN: the IDLE search always starts at
// channel 0 (lowest index wins) and the round-robin pointer stays at 0.
// The default build, with the macro undefined, searches round-robin starting at
// the channel after the last one granted.
//
// Handshake semantics (both sides): a beat transfers on a rising clk edge where
// tvalid and tready are both 1. A source holds tdata/tlast stable and keeps
// tvalid high until the transfer. This block never lowers m_axis_0_tvalid, and
// never changes the output beat, until the beat has been accepted.
module axis_packet_arbiter #(
    parameter int  DATA_WIDTH = 16,
    parameter int  CHANNELS   = 4,
    localparam int ID_WIDTH   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH*CHANNELS-1:0] s_axis_0_tdata,
    input  logic [CHANNELS-1:0]            s_axis_0_tvalid,
    input  logic [CHANNELS-1:0]            s_axis_0_tlast,
    output logic [CHANNELS-1:0]            s_axis_0_tready,
    output logic [DATA_WIDTH-1:0]          m_axis_0_tdata,
    output logic [ID_WIDTH-1:0]            m_axis_0_tid,
    output logic                           m_axis_0_tlast,
    output logic                           m_axis_0_tvalid,
    input  logic                           m_axis_0_tready
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // The FSM state, the grant g and the pointer p are plain named registers.
    // They can be observed hierarchically.
    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   g_q, g_d;
    logic [ID_WIDTH-1:0]   p_q, p_d;

    logic [ID_WIDTH-1:0]   search_start;
    logic [ID_WIDTH-1:0]   sel_id;
    logic                  any_valid;
    logic                  in_hs;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  grant_last;
    logic [ID_WIDTH-1:0]   next_ptr;

`ifdef AXIS_ARB_FIXED_PRIO_EN
    assign search_start = '0;
    assign next_ptr     = '0;
`else
    assign search_start = p_q;
    assign next_ptr     = (g_q == ID_WIDTH'(CHANNELS - 1)) ? '0 : g_q + ID_WIDTH'(1);
`endif

    assign any_valid = |s_axis_0_tvalid;
    assign in_hs     = |(s_axis_0_tready & s_axis_0_tvalid);

    // Cyclic search: take the lowest valid index at or above the start point.
    // If there is none, wrap around and take the lowest valid index below it.
    always_comb begin
        logic                hi_found;
        logic [ID_WIDTH-1:0] hi_id;
        logic [ID_WIDTH-1:0] lo_id;
        hi_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (s_axis_0_tvalid[c]) begin
                if (ID_WIDTH'(c) >= search_start) begin
                    hi_found = 1'b1;
                    hi_id    = ID_WIDTH'(c);
                end else begin
                    lo_id = ID_WIDTH'(c);
                end
            end
        end
        sel_id = hi_found ? hi_id : lo_id;
    end

    // Select the data and tlast of the granted channel.
    always_comb begin
        grant_data = '0;
        grant_last = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (g_q == ID_WIDTH'(c)) begin
                grant_data = s_axis_0_tdata[c*DATA_WIDTH +: DATA_WIDTH];
                grant_last = s_axis_0_tlast[c];
            end
        end
    end

    // FSM state register, together with the grant and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            p_q     <= p_d;
        end
    end

    // FSM next state: the grant is taken in IDLE and released only on a tlast transfer.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = GRANT;
                    g_d     = sel_id;
                end
            end
            GRANT: begin
                if (in_hs && grant_last) begin
                    state_d = IDLE;
                    p_d     = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: in GRANT, only the granted channel sees tready.
    // tready is high when the output register is free, or is being emptied this cycle.
    always_comb begin
        s_axis_0_tready = '0;
        if (state_q == GRANT) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (g_q == ID_WIDTH'(c)) begin
                    s_axis_0_tready[c] = m_axis_0_tready || !m_axis_0_tvalid;
                end
            end
        end
    end

    // Output register stage: an accepted input beat loads the register.
    // An accepted output beat with no input beat in the same cycle empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_0_tvalid <= 1'b0;
            m_axis_0_tdata  <= '0;
            m_axis_0_tlast  <= 1'b0;
            m_axis_0_tid    <= '0;
        end else if (in_hs) begin
            m_axis_0_tvalid <= 1'b1;
            m_axis_0_tdata  <= grant_data;
            m_axis_0_tlast  <= grant_last;
            m_axis_0_tid    <= g_q;
        end else if (m_axis_0_tvalid && m_axis_0_tready) begin
            m_axis_0_tvalid <= 1'b0;
        end
    end

endmodule
